// File: rtl/rgmii_phy_speed_poll.sv
// rgmii_phy_speed_poll
// MDIO management master that periodically reads the PHY specific status
// register and resolves Ethernet speed, duplex and link for the RGMII MAC
// clock divider.
//
// Ports:
//   clk           125 MHz reference clock
//   reset_n       asynchronous active-low reset
//   poll_req      request an immediate poll (pulse or level)
//   mdio_in       MDIO pad input (asynchronous, synchronised here)
//   mdc           management clock to PHY
//   mdio_out      MDIO drive value
//   mdio_oe       MDIO output enable, 1 = drive
//   eth_speed     resolved speed: 10 = 1000, 01 = 100, 00 = 10 Mb/s
//   duplex        1 = full duplex
//   link_up       resolved link up
//   speed_change  one-cycle pulse after eth_speed takes a new value
//   mdio_err      sticky turnaround error, cleared by the next good frame
module rgmii_phy_speed_poll #(
    parameter int unsigned CLK_DIV     = 25,
    parameter logic [4:0]  PHY_ADDR    = 5'd0,
    parameter logic [4:0]  STAT_REG    = 5'd17,
    parameter int unsigned POLL_CYCLES = 125000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       poll_req,
    input  logic       mdio_in,
    output logic       mdc,
    output logic       mdio_out,
    output logic       mdio_oe,
    output logic [1:0] eth_speed,
    output logic       duplex,
    output logic       link_up,
    output logic       speed_change,
    output logic       mdio_err
);

    localparam int unsigned DIV_W   = 8;
    localparam int unsigned TIMER_W = 24;
    localparam int unsigned BIT_W   = 6;
    localparam int unsigned HDR_W   = 14;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_CYCLES - 1);
    // ST=01, OP=10 (read), PHY address, register address
    localparam logic [HDR_W-1:0]   HDR_BITS   = {2'b01, 2'b10, PHY_ADDR, STAT_REG};

    typedef enum logic [2:0] {
        S_WAIT,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_UPD
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_idx;
    logic [TIMER_W-1:0] timer;
    logic               pending;
    logic               mdio_s1;
    logic               mdio_s2;
    logic [HDR_W-1:0]   hdr_sr;
    logic [15:0]        data_sr;
    logic               frame_err;
    logic [1:0]         speed_prev;

    logic               running_c;
    logic               wrap_c;
    logic               rise_c;
    logic               fall_c;
    logic               start_c;
    logic [BIT_W-1:0]   next_idx_c;

    // MDC divider strobes and the frame start condition
    always_comb begin
        running_c  = (state == S_PRE) || (state == S_HDR) ||
                     (state == S_TA)  || (state == S_DATA);
        wrap_c     = running_c && (div_cnt == DIV_LAST);
        rise_c     = wrap_c && !mdc;
        fall_c     = wrap_c && mdc;
        next_idx_c = bit_idx + BIT_W'(1);
        start_c    = (state == S_WAIT) && (pending || poll_req || (timer == TIMER_LAST));
    end

    // Next-state logic; frame phases advance on MDC falling edges
    always_comb begin
        state_next = state;
        case (state)
            S_WAIT: if (start_c) state_next = S_PRE;
            S_PRE:  if (fall_c && (bit_idx == BIT_W'(31))) state_next = S_HDR;
            S_HDR:  if (fall_c && (bit_idx == BIT_W'(45))) state_next = S_TA;
            S_TA:   if (fall_c && (bit_idx == BIT_W'(47))) state_next = S_DATA;
            S_DATA: if (fall_c && (bit_idx == BIT_W'(63))) state_next = S_UPD;
            S_UPD:  state_next = S_WAIT;
            default: state_next = S_WAIT;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Frame datapath, pin drivers and resolved status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt      <= '0;
            bit_idx      <= '0;
            timer        <= '0;
            pending      <= 1'b0;
            mdio_s1      <= 1'b1;
            mdio_s2      <= 1'b1;
            hdr_sr       <= '0;
            data_sr      <= '0;
            frame_err    <= 1'b0;
            mdc          <= 1'b0;
            mdio_out     <= 1'b1;
            mdio_oe      <= 1'b0;
            eth_speed    <= 2'b10;
            duplex       <= 1'b1;
            link_up      <= 1'b0;
            speed_change <= 1'b0;
            speed_prev   <= 2'b10;
            mdio_err     <= 1'b0;
        end else begin
            mdio_s1 <= mdio_in;
            mdio_s2 <= mdio_s1;

            // a request arriving on the start cycle is served by that frame
            pending <= start_c ? 1'b0 : (pending | poll_req);

            if ((state == S_WAIT) && !start_c) begin
                timer <= timer + TIMER_W'(1);
            end else begin
                timer <= '0;
            end

            if (start_c) begin
                div_cnt   <= '0;
                bit_idx   <= '0;
                mdc       <= 1'b0;
                mdio_out  <= 1'b1;
                mdio_oe   <= 1'b1;
                hdr_sr    <= HDR_BITS;
                frame_err <= 1'b0;
            end else if (running_c) begin
                div_cnt <= wrap_c ? '0 : div_cnt + DIV_W'(1);
                if (wrap_c) begin
                    mdc <= ~mdc;
                end
                if (fall_c) begin
                    bit_idx <= next_idx_c;
                    if ((next_idx_c != '0) && (next_idx_c < BIT_W'(32))) begin
                        mdio_out <= 1'b1;
                        mdio_oe  <= 1'b1;
                    end else if ((next_idx_c >= BIT_W'(32)) && (next_idx_c < BIT_W'(46))) begin
                        mdio_out <= hdr_sr[HDR_W-1];
                        mdio_oe  <= 1'b1;
                        hdr_sr   <= {hdr_sr[HDR_W-2:0], 1'b0};
                    end else begin
                        mdio_out <= 1'b1;
                        mdio_oe  <= 1'b0;
                    end
                end
                if (rise_c) begin
                    // PHY must pull the second turnaround bit low
                    if ((bit_idx == BIT_W'(47)) && mdio_s2) begin
                        frame_err <= 1'b1;
                        mdio_err  <= 1'b1;
                    end
                    if (bit_idx >= BIT_W'(48)) begin
                        data_sr <= {data_sr[14:0], mdio_s2};
                    end
                end
            end else begin
                div_cnt  <= '0;
                mdc      <= 1'b0;
                mdio_out <= 1'b1;
                mdio_oe  <= 1'b0;
            end

            if ((state == S_UPD) && !frame_err) begin
                mdio_err <= 1'b0;
                if (data_sr[11] && data_sr[10]) begin
                    link_up <= 1'b1;
                    duplex  <= data_sr[13];
                    // 2'b11 is a reserved speed code; keep the divider where it is
                    if (data_sr[15:14] != 2'b11) begin
                        eth_speed <= data_sr[15:14];
                    end
                end else begin
                    link_up <= 1'b0;
                end
            end

            speed_prev   <= eth_speed;
            speed_change <= (eth_speed != speed_prev);
        end
    end

endmodule

// File: tb/tb_rgmii_phy_speed_poll.sv
// tb_rgmii_phy_speed_poll
// Directed bench for rgmii_phy_speed_poll with CLK_DIV=2, POLL_CYCLES=100 and
// a cycle-level PHY model that answers register reads on mdio_in.
module tb_rgmii_phy_speed_poll;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       poll_req = 1'b0;
    logic       mdio_in = 1'b1;
    logic       mdc;
    logic       mdio_out;
    logic       mdio_oe;
    logic [1:0] eth_speed;
    logic       duplex;
    logic       link_up;
    logic       speed_change;
    logic       mdio_err;

    int checks = 0;
    int failures = 0;

    rgmii_phy_speed_poll #(
        .CLK_DIV    (2),
        .PHY_ADDR   (5'd0),
        .STAT_REG   (5'd17),
        .POLL_CYCLES(100)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .poll_req    (poll_req),
        .mdio_in     (mdio_in),
        .mdc         (mdc),
        .mdio_out    (mdio_out),
        .mdio_oe     (mdio_oe),
        .eth_speed   (eth_speed),
        .duplex      (duplex),
        .link_up     (link_up),
        .speed_change(speed_change),
        .mdio_err    (mdio_err)
    );

    always #4 clk = ~clk;

    // PHY model: after the r-th MDC rise of a frame, present frame bit r so it
    // is stable through the synchroniser before the next rise samples it.
    logic [15:0] phy_data = 16'h0000;
    logic        no_phy = 1'b0;
    int          rise_cnt = 0;
    logic        mdc_q = 1'b0;
    logic        oe_q = 1'b0;

    function automatic logic phy_bit(input int n, input logic [15:0] d, input logic np);
        if (np) return 1'b1;
        if (n == 47) return 1'b0;
        if (n >= 48 && n <= 63) return d[63 - n];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        #1;
        if (mdio_oe && !oe_q) rise_cnt = 0;
        if (mdc && !mdc_q) begin
            rise_cnt = rise_cnt + 1;
            mdio_in  = phy_bit(rise_cnt, phy_data, no_phy);
        end
        mdc_q = mdc;
        oe_q  = mdio_oe;
    end

    // Per-frame observations gathered by run_frame
    int          rises, first_rise, last_fall, sc_cnt, sc_first, hdr_n, gap;
    logic [63:0] hdr_cap;
    logic [63:0] hdr_exp;
    logic [1:0]  snap_speed;
    logic        snap_link, snap_dup, snap_err, oe257, oe258, upd_mdc, upd_oe;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (mdio_oe !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
    endtask

    // Called one step after PRE entry; observes 258 clk cycles of the frame.
    task automatic run_frame(input logic req);
        logic prev;
        prev = mdc;
        rises = 0; first_rise = 0; last_fall = 0; sc_cnt = 0; sc_first = 0;
        hdr_n = 0; hdr_cap = '0;
        for (int idx = 1; idx <= 258; idx++) begin
            step();
            if (mdc && !prev) begin
                rises++;
                if (rises == 1) first_rise = idx;
                if (mdio_oe) begin
                    hdr_cap = {hdr_cap[62:0], mdio_out};
                    hdr_n++;
                end
            end
            if (!mdc && prev) last_fall = idx;
            prev = mdc;
            if (speed_change) begin
                sc_cnt++;
                if (sc_first == 0) sc_first = idx;
            end
            if (idx == 256) begin
                upd_mdc = mdc;
                upd_oe  = mdio_oe;
            end
            if (idx == 257) begin
                snap_speed = eth_speed;
                snap_link  = link_up;
                snap_dup   = duplex;
                snap_err   = mdio_err;
                oe257      = mdio_oe;
            end
            if (idx == 258) oe258 = mdio_oe;
            if (req) poll_req = (idx == 219) || (idx == 239);
        end
        poll_req = 1'b0;
    endtask

    initial begin
        hdr_exp = {18'b0, 32'hFFFF_FFFF, 14'b01_10_00000_10001};

        // Reset values
        #2 reset_n = 1'b0;
        #1;
        check("rst_mdc", 64'(mdc), 64'd0);
        check("rst_mdio_out", 64'(mdio_out), 64'd1);
        check("rst_mdio_oe", 64'(mdio_oe), 64'd0);
        check("rst_speed", 64'(eth_speed), 64'd2);
        check("rst_duplex", 64'(duplex), 64'd1);
        check("rst_link", 64'(link_up), 64'd0);
        check("rst_speed_change", 64'(speed_change), 64'd0);
        check("rst_mdio_err", 64'(mdio_err), 64'd0);
        repeat (3) step();
        reset_n = 1'b1;

        // Frame 1: 1000 Mb/s full duplex, first poll at POLL_CYCLES
        phy_data = 16'hAC00; no_phy = 1'b0;
        wait_start(gap);
        check("first_pre_cycle", 64'(gap), 64'd100);
        run_frame(1'b0);
        check("f1_first_rise", 64'(first_rise), 64'd2);
        check("f1_mdc_periods", 64'(rises), 64'd64);
        check("f1_last_fall", 64'(last_fall), 64'd256);
        check("f1_hdr_bits", 64'(hdr_n), 64'd46);
        check("f1_hdr_pattern", hdr_cap, hdr_exp);
        check("f1_upd_mdc", 64'(upd_mdc), 64'd0);
        check("f1_upd_oe", 64'(upd_oe), 64'd0);
        check("f1_speed", 64'(snap_speed), 64'd2);
        check("f1_link", 64'(snap_link), 64'd1);
        check("f1_duplex", 64'(snap_dup), 64'd1);
        check("f1_err", 64'(snap_err), 64'd0);
        check("f1_speed_change", 64'(sc_cnt), 64'd0);
        check("f1_no_extra", 64'(oe258), 64'd0);

        // Frame 2: 100 Mb/s
        phy_data = 16'h6C00;
        wait_start(gap);
        check("f2_gap", 64'(gap), 64'd99);
        run_frame(1'b0);
        check("f2_speed", 64'(snap_speed), 64'd1);
        check("f2_link", 64'(snap_link), 64'd1);
        check("f2_sc_count", 64'(sc_cnt), 64'd1);
        check("f2_sc_cycle", 64'(sc_first), 64'd258);

        // Frame 3: 10 Mb/s
        phy_data = 16'h2C00;
        wait_start(gap);
        run_frame(1'b0);
        check("f3_speed", 64'(snap_speed), 64'd0);
        check("f3_sc_count", 64'(sc_cnt), 64'd1);
        check("f3_sc_cycle", 64'(sc_first), 64'd258);

        // Frame 4: not resolved -> link down, speed held
        phy_data = 16'h6800;
        wait_start(gap);
        run_frame(1'b0);
        check("f4_link", 64'(snap_link), 64'd0);
        check("f4_speed", 64'(snap_speed), 64'd0);
        check("f4_duplex", 64'(snap_dup), 64'd1);
        check("f4_sc_count", 64'(sc_cnt), 64'd0);

        // Frame 5: reserved speed code -> speed held, link up
        phy_data = 16'hEC00;
        wait_start(gap);
        run_frame(1'b0);
        check("f5_speed", 64'(snap_speed), 64'd0);
        check("f5_link", 64'(snap_link), 64'd1);
        check("f5_sc_count", 64'(sc_cnt), 64'd0);

        // Frame 6: no PHY, turnaround stays high
        no_phy = 1'b1;
        wait_start(gap);
        run_frame(1'b0);
        check("f6_err", 64'(snap_err), 64'd1);
        check("f6_speed", 64'(snap_speed), 64'd0);
        check("f6_link", 64'(snap_link), 64'd1);
        check("f6_duplex", 64'(snap_dup), 64'd1);
        check("f6_sc_count", 64'(sc_cnt), 64'd0);

        // Frame 7: good frame clears the error; 100 Mb/s half duplex
        no_phy = 1'b0; phy_data = 16'h4C00;
        wait_start(gap);
        run_frame(1'b0);
        check("f7_err", 64'(snap_err), 64'd0);
        check("f7_speed", 64'(snap_speed), 64'd1);
        check("f7_duplex", 64'(snap_dup), 64'd0);
        check("f7_sc_count", 64'(sc_cnt), 64'd1);

        // Frame 8: two poll_req pulses during DATA -> one back-to-back frame
        phy_data = 16'hAC00;
        wait_start(gap);
        run_frame(1'b1);
        check("f8_speed", 64'(snap_speed), 64'd2);
        check("f8_duplex", 64'(snap_dup), 64'd1);
        check("f8_oe_wait", 64'(oe257), 64'd0);
        check("f8_extra_start", 64'(oe258), 64'd1);
        phy_data = 16'h2C00;
        run_frame(1'b0);
        check("f8b_speed", 64'(snap_speed), 64'd0);
        check("f8b_sc_count", 64'(sc_cnt), 64'd1);
        check("f8b_no_second_extra", 64'(oe258), 64'd0);
        wait_start(gap);
        check("f9_gap", 64'(gap), 64'd99);
        run_frame(1'b0);
        check("f9_speed", 64'(snap_speed), 64'd0);
        check("f9_sc_count", 64'(sc_cnt), 64'd0);

        // poll_req in WAIT when timer == 10 -> PRE next cycle
        repeat (9) step();
        check("req_before", 64'(mdio_oe), 64'd0);
        poll_req = 1'b1;
        step();
        poll_req = 1'b0;
        check("req_pre", 64'(mdio_oe), 64'd1);

        // Reset mid-DATA while mdc is high
        repeat (222) step();
        check("pre_rst_mdc", 64'(mdc), 64'd1);
        check("pre_rst_link", 64'(link_up), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_mdc", 64'(mdc), 64'd0);
        check("mid_rst_oe", 64'(mdio_oe), 64'd0);
        check("mid_rst_speed", 64'(eth_speed), 64'd2);
        check("mid_rst_link", 64'(link_up), 64'd0);
        check("mid_rst_sc", 64'(speed_change), 64'd0);
        repeat (3) step();
        reset_n = 1'b1;

        // First frame after reset: timing and header pattern
        phy_data = 16'hAC00;
        wait_start(gap);
        check("post_rst_pre_cycle", 64'(gap), 64'd100);
        run_frame(1'b0);
        check("post_rst_hdr_bits", 64'(hdr_n), 64'd46);
        check("post_rst_hdr_pattern", hdr_cap, hdr_exp);
        check("post_rst_speed", 64'(snap_speed), 64'd2);
        check("post_rst_link", 64'(snap_link), 64'd1);
        check("post_rst_sc_count", 64'(sc_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
